// File: rtl/drive_pkg.sv
// Shared definitions for the H-bridge drive sequencer: command codes, beacon classes,
// state encoding and motor-reversal detection.
package drive_pkg;

  localparam logic [3:0] CMD_FORWARD = 4'b1010;
  localparam logic [3:0] CMD_BACK    = 4'b0101;
  localparam logic [3:0] CMD_LEFT    = 4'b1000;
  localparam logic [3:0] CMD_RIGHT   = 4'b0010;
  localparam logic [3:0] CMD_P_LEFT  = 4'b1001;
  localparam logic [3:0] CMD_P_RIGHT = 4'b0110;

  localparam logic [3:0] BCN_F = 4'b0011;
  localparam logic [3:0] BCN_C = 4'b1100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RUN   = 3'b001,
    ST_DEAD  = 3'b010,
    ST_HOLD  = 3'b011,
    ST_COOL  = 3'b100,
    ST_FAULT = 3'b101
  } state_e;

  function automatic logic pair_flips(input logic [1:0] a, input logic [1:0] b);
    return ((a == 2'b10) && (b == 2'b01)) || ((a == 2'b01) && (b == 2'b10));
  endfunction

  // A reversal on either motor needs the bridge fully off before re-driving.
  function automatic logic is_reversal(input logic [3:0] cur, input logic [3:0] nxt);
    return pair_flips(cur[3:2], nxt[3:2]) || pair_flips(cur[1:0], nxt[1:0]);
  endfunction

endpackage

// File: rtl/drive_sequencer_oc_debounce.sv
// Over-current filter: trips after OC_FILTER consecutive cycles of an active limiter flag.
// Trip is combinational from the registered count; count clears when idle or disabled.
module oc_debounce #(
  parameter int OC_FILTER = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ocl_n,
  input  logic       en,
  output logic       trip
);

  localparam int W = (OC_FILTER > 1) ? $clog2(OC_FILTER) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         active;

  always_comb begin
    active = en && (ocl_n != 2'b11);
    trip   = active && (cnt_q == W'(OC_FILTER - 1));
    cnt_d  = cnt_q + 1'b1;
    if (!active || trip) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// H-bridge sequencer: PWM gating, reversal dead-time, beacon hold/slow, over-current retry/fault.
// All outputs registered; an input change reaches ja one cycle later.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int PERIOD    = 1666667,
  parameter int DEADTIME  = 10000,
  parameter int OC_FILTER = 20000000,
  parameter int COOL_TIME = 50000000,
  parameter int MAX_RETRY = 3,
  parameter int CW        = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  lf_cmd,
  input  logic        lf_valid,
  input  logic [20:0] duty,
  input  logic [3:0]  beacon,
  input  logic [1:0]  ocl_n,
  input  logic        clr_fault,
  output logic [3:0]  ja,
  output logic [2:0]  state,
  output logic [1:0]  retries,
  output logic        fault
);

  state_e         state_q, state_d;
  logic [20:0]    cnt_q, cnt_d;
  logic [CW-1:0]  timer_q, timer_d;
  logic [3:0]     cur_q, cur_d;
  logic [3:0]     pend_q, pend_d;
  logic [1:0]     retries_q, retries_d;
  logic [3:0]     ja_q, ja_d;
  logic           fault_q, fault_d;

  logic [20:0]    eff_duty;
  logic           pwm_on;
  logic           oc_en;
  logic           oc_trip;
  logic [1:0]     retry_inc;

  assign oc_en = (state_q == ST_RUN) || (state_q == ST_DEAD) || (state_q == ST_HOLD);

  oc_debounce #(
    .OC_FILTER (OC_FILTER)
  ) u_oc_debounce (
    .clk   (clk),
    .rst   (rst),
    .ocl_n (ocl_n),
    .en    (oc_en),
    .trip  (oc_trip)
  );

  // Duty at or above PERIOD never drops below the counter, giving 100 % on-time.
  always_comb begin
    eff_duty = (beacon == BCN_F) ? {1'b0, duty[20:1]} : duty;
    pwm_on   = (cnt_q < eff_duty);
    cnt_d    = (cnt_q == 21'(PERIOD - 1)) ? '0 : cnt_q + 21'd1;
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    timer_d   = timer_q + 1'b1;
    retries_d = retries_q;
    pend_d    = pend_q;
    retry_inc = (retries_q == 2'(MAX_RETRY)) ? retries_q : retries_q + 2'd1;

    if (lf_valid && (state_q != ST_FAULT)) begin
      pend_d = lf_cmd;
    end

    if (state_q == ST_FAULT) begin
      if (clr_fault) begin
        state_d   = ST_IDLE;
        retries_d = '0;
      end
    end else if (oc_trip) begin
      retries_d = retry_inc;
      cur_d     = '0;
      timer_d   = '0;
      state_d   = (retry_inc == 2'(MAX_RETRY)) ? ST_FAULT : ST_COOL;
    end else if (state_q == ST_COOL) begin
      if (timer_q == CW'(COOL_TIME - 1)) begin
        state_d = en ? ST_RUN : ST_IDLE;
      end
    end else if (!en) begin
      state_d = ST_IDLE;
      cur_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (beacon == BCN_C) begin
            state_d = ST_HOLD;
            cur_d   = '0;
          end else if (pend_d != cur_q) begin
            if (is_reversal(cur_q, pend_d)) begin
              state_d = ST_DEAD;
              timer_d = '0;
            end else begin
              cur_d = pend_d;
            end
          end
        end
        ST_HOLD: begin
          if (beacon != BCN_C) begin
            state_d = ST_RUN;
          end
        end
        ST_DEAD: begin
          if (timer_q == CW'(DEADTIME - 1)) begin
            cur_d   = pend_d;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Only RUN ever drives the bridge; every other state forces all-off.
    ja_d    = ((state_d == ST_RUN) && pwm_on) ? cur_d : 4'b0000;
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      cur_q     <= '0;
      pend_q    <= '0;
      retries_q <= '0;
      ja_q      <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      retries_q <= retries_d;
      ja_q      <= ja_d;
      fault_q   <= fault_d;
    end
  end

  assign ja      = ja_q;
  assign state   = state_q;
  assign retries = retries_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the registered outputs.
module tb_drive_sequencer;
  import drive_pkg::*;

  localparam int P = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  lf_cmd;
  logic        lf_valid;
  logic [20:0] duty;
  logic [3:0]  beacon;
  logic [1:0]  ocl_n;
  logic        clr_fault;
  logic [3:0]  ja;
  logic [2:0]  state;
  logic [1:0]  retries;
  logic        fault;

  drive_sequencer #(
    .PERIOD    (P),
    .DEADTIME  (4),
    .OC_FILTER (8),
    .COOL_TIME (16),
    .MAX_RETRY (2),
    .CW        (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lf_cmd    (lf_cmd),
    .lf_valid  (lf_valid),
    .duty      (duty),
    .beacon    (beacon),
    .ocl_n     (ocl_n),
    .clr_fault (clr_fault),
    .ja        (ja),
    .state     (state),
    .retries   (retries),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [3:0] ja;
    logic [2:0] st;
    logic [1:0] rt;
    logic       f;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   rel = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.c < cyc) begin
        failures++;
        $display("FAIL %s cyc=%0d: expectation never sampled (now %0d)", e.name, e.c, cyc);
      end else if ({ja, state, retries, fault} !== {e.ja, e.st, e.rt, e.f}) begin
        failures++;
        $display("FAIL %s cyc=%0d: got ja=%b state=%b retries=%0d fault=%b, want ja=%b state=%b retries=%0d fault=%b",
                 e.name, cyc, ja, state, retries, fault, e.ja, e.st, e.rt, e.f);
      end
    end
  end

  task automatic push1(input int c, input logic [3:0] j, input logic [2:0] st,
                       input logic [1:0] rt, input logic f, input string name);
    exp_t x;
    x.c = c; x.ja = j; x.st = st; x.rt = rt; x.f = f; x.name = name;
    sb.push_back(x);
  endtask

  // ja at cycle c reflects the PWM count of cycle c-1, counted from the last reset release.
  task automatic exp_pwm(input int c0, input int n, input logic [3:0] cmd, input int ed,
                         input logic [2:0] st, input logic [1:0] rt, input string name);
    for (int i = 0; i < n; i++) begin
      int c;
      int ph;
      c  = c0 + i;
      ph = (c - 1 - rel) % P;
      push1(c, (ph < ed) ? cmd : 4'b0000, st, rt, 1'b0, name);
    end
  endtask

  task automatic exp_zero(input int c0, input int n, input logic [2:0] st,
                          input logic [1:0] rt, input logic f, input string name);
    for (int i = 0; i < n; i++) push1(c0 + i, 4'b0000, st, rt, f, name);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] cmd);
    lf_cmd   = cmd;
    lf_valid = 1'b1;
    @(posedge clk);
    #1;
    lf_valid = 1'b0;
  endtask

  initial begin
    int r, r2, r3, wait_cnt;
    rst = 1'b1; en = 1'b1; lf_cmd = 4'b0; lf_valid = 1'b0; duty = 21'd40;
    beacon = 4'b0000; ocl_n = 2'b11; clr_fault = 1'b0;
    exp_zero(1, 2, ST_IDLE, 2'd0, 1'b0, "reset_state");
    goto(3);

    // Release with FORWARD strobed: IDLE -> RUN, then PWM at 40/100.
    r = cyc; rel = r; rst = 1'b0;
    push1(r + 1, 4'b0000, ST_RUN, 2'd0, 1'b0, "idle_to_run");
    exp_pwm(r + 2, 200, CMD_FORWARD, 40, ST_RUN, 2'd0, "fwd_d40");
    strobe(CMD_FORWARD);

    goto(r + 201);
    exp_pwm(r + 202, 50, CMD_LEFT, 40, ST_RUN, 2'd0, "fwd_to_left_no_dead");
    strobe(CMD_LEFT);
    goto(r + 251);
    exp_pwm(r + 252, 50, CMD_FORWARD, 40, ST_RUN, 2'd0, "left_to_fwd");
    strobe(CMD_FORWARD);

    goto(r + 301);
    exp_zero(r + 302, 4, ST_DEAD, 2'd0, 1'b0, "reversal_dead");
    exp_pwm(r + 306, 100, CMD_BACK, 40, ST_RUN, 2'd0, "back_after_dead");
    strobe(CMD_BACK);

    goto(r + 405);
    beacon = BCN_F;
    exp_pwm(r + 406, 100, CMD_BACK, 20, ST_RUN, 2'd0, "beacon_f_half");

    goto(r + 505);
    beacon = BCN_C;
    exp_zero(r + 506, 15, ST_HOLD, 2'd0, 1'b0, "beacon_c_hold");
    goto(r + 510);
    strobe(CMD_FORWARD);
    goto(r + 520);
    beacon = 4'b0000;
    push1(r + 521, 4'b0000, ST_RUN, 2'd0, 1'b0, "hold_exit");
    exp_pwm(r + 522, 86, CMD_FORWARD, 40, ST_RUN, 2'd0, "hold_pending_fwd");

    // 7 active cycles must not trip; 8 must.
    goto(r + 560); ocl_n = 2'b10;
    goto(r + 567); ocl_n = 2'b11;
    goto(r + 600); ocl_n = 2'b10;
    exp_zero(r + 608, 16, ST_COOL, 2'd1, 1'b0, "trip1_cool");
    push1(r + 624, 4'b0000, ST_RUN, 2'd1, 1'b0, "cool_exit");
    exp_pwm(r + 625, 43, CMD_FORWARD, 40, ST_RUN, 2'd1, "run_after_cool");
    goto(r + 608); ocl_n = 2'b11;

    goto(r + 660); ocl_n = 2'b10;
    exp_zero(r + 668, 23, ST_FAULT, 2'd2, 1'b1, "trip2_fault");
    goto(r + 668); ocl_n = 2'b11;
    goto(r + 670); en = 1'b0;
    goto(r + 675); en = 1'b1;
    goto(r + 680); strobe(CMD_BACK);
    goto(r + 690);
    clr_fault = 1'b1;
    push1(r + 691, 4'b0000, ST_IDLE, 2'd0, 1'b0, "clr_fault_idle");
    push1(r + 692, 4'b0000, ST_RUN, 2'd0, 1'b0, "clr_fault_run");
    exp_pwm(r + 693, 68, CMD_FORWARD, 40, ST_RUN, 2'd0, "fault_ignored_back");
    goto(r + 691); clr_fault = 1'b0;

    // Reset in the middle of a dead-time window.
    goto(r + 760);
    exp_zero(r + 761, 2, ST_DEAD, 2'd0, 1'b0, "dead_before_rst");
    strobe(CMD_BACK);
    goto(r + 763);
    rst = 1'b1;
    exp_zero(r + 763, 3, ST_IDLE, 2'd0, 1'b0, "rst_mid_dead");
    goto(r + 766);
    rst = 1'b0; r2 = cyc; rel = r2;
    push1(r2, 4'b0000, ST_IDLE, 2'd0, 1'b0, "rst_release_idle");
    exp_zero(r2 + 1, 5, ST_RUN, 2'd0, 1'b0, "pend_cleared");
    goto(r2 + 5);
    exp_pwm(r2 + 6, 62, CMD_FORWARD, 40, ST_RUN, 2'd0, "pwm_phase_reset");
    strobe(CMD_FORWARD);

    // Reset in the middle of a cooldown.
    goto(r2 + 60); ocl_n = 2'b10;
    exp_zero(r2 + 68, 6, ST_COOL, 2'd1, 1'b0, "cool_before_rst");
    goto(r2 + 68); ocl_n = 2'b11;
    goto(r2 + 74);
    rst = 1'b1;
    exp_zero(r2 + 74, 2, ST_IDLE, 2'd0, 1'b0, "rst_mid_cool");
    goto(r2 + 76);
    rst = 1'b0; r3 = cyc; rel = r3;
    push1(r3, 4'b0000, ST_IDLE, 2'd0, 1'b0, "rst2_release_idle");
    push1(r3 + 1, 4'b0000, ST_RUN, 2'd0, 1'b0, "rst2_run");
    goto(r3 + 1);
    exp_pwm(r3 + 2, 49, CMD_FORWARD, 40, ST_RUN, 2'd0, "rst2_fwd");
    strobe(CMD_FORWARD);

    goto(r3 + 50);
    duty = 21'd0;
    exp_pwm(r3 + 51, 100, CMD_FORWARD, 0, ST_RUN, 2'd0, "duty_zero");
    goto(r3 + 150);
    duty = 21'd120;
    exp_pwm(r3 + 151, 100, CMD_FORWARD, 120, ST_RUN, 2'd0, "duty_saturate");
    goto(r3 + 250);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 50) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Owns the H-bridge output port. It takes motor commands from the line follower and applies PWM gating at a programmable duty. It inserts dead-time on any motor reversal, halts on the C beacon, and halves speed on the F beacon. It also runs the over-current retry/fault state machine. It sits between the line-follow/beacon logic and the JA pins.

Parameters:
PERIOD, 1666667, PWM period in clk cycles (60 Hz at 100 MHz)
DEADTIME, 10000, all-off cycles inserted on direction reversal (100 us)
OC_FILTER, 20000000, cycles the current limiter must stay continuously active before trip (200 ms)
COOL_TIME, 50000000, all-off cooldown cycles after a trip (500 ms)
MAX_RETRY, 3, trips allowed before the fault latches
CW, 26, width of the shared timer

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-high reset
en  in  1  drive enable; low forces IDLE
lf_cmd  in  4  line-follower command {L+,L-,R+,R-}; FORWARD=1010, BACK=0101, LEFT=1000, RIGHT=0010, P_LEFT=1001, P_RIGHT=0110
lf_valid  in  1  single-cycle strobe; latch lf_cmd
duty  in  21  PWM on-count; values >= PERIOD saturate to 100 %
beacon  in  4  frequency class: 0000 none, 0011 F, 1100 C; other codes are treated as none
ocl_n  in  2  current-limiter flags, active-low per motor; idle = 11
clr_fault  in  1  single-cycle strobe; leaves FAULT
ja  out  4  H-bridge drive
state  out  3  IDLE=000, RUN=001, DEAD=010, HOLD=011, COOL=100, FAULT=101
retries  out  2  trip count since last reset/clear
fault  out  1  high only in FAULT

Behaviour:
- Reset values: ja=0, state=IDLE, retries=0, fault=0, pwm counter=0, timer=0, OC filter=0, cur_cmd=0, pend_cmd=0.
- All outputs are registered. A change in inputs appears on ja one cycle later.
- PWM counter runs 0..PERIOD-1 in every state and wraps to 0. pwm_on = (cnt < eff_duty).
  - eff_duty = duty when beacon != F.
  - eff_duty = duty>>1 when beacon == F.
  - duty=0 gives ja always 0.
- lf_valid loads pend_cmd in any state except FAULT.
- Reversal means any motor pair changes 10->01 or 01->10 between cur_cmd and pend_cmd.
- OC filter:
  - Counts while ocl_n != 11 and clears to 0 when ocl_n == 11.
  - Counts only in RUN, DEAD or HOLD.
  - Trip when the count reaches OC_FILTER-1 while still active.
- State transitions, highest priority first:
  - FAULT: ja=0. clr_fault -> IDLE, retries=0, fault=0. en is ignored.
  - OC trip (in RUN/DEAD/HOLD): retries+1. If the new value == MAX_RETRY, go to FAULT; otherwise go to COOL with timer=0. cur_cmd=0.
  - COOL: ja=0. When timer == COOL_TIME-1, go to RUN if en, otherwise IDLE. The OC filter is held at 0 during COOL.
  - en low (any non-FAULT, non-COOL state): go to IDLE, ja=0, cur_cmd=0.
  - IDLE with en high: go to RUN.
  - RUN, beacon == C: go to HOLD, cur_cmd=0.
  - HOLD: ja=0. When beacon != C, go to RUN.
  - RUN, pend_cmd != cur_cmd:
    - Reversal: go to DEAD with timer=0.
    - Otherwise: cur_cmd=pend_cmd on the same cycle.
  - DEAD: ja=0. When timer == DEADTIME-1, cur_cmd=pend_cmd and go to RUN. A new pend_cmd arriving during DEAD is re-evaluated on return to RUN.
  - RUN output: ja = pwm_on ? cur_cmd : 0.
- Simultaneous events:
  - OC trip beats beacon C, reversal and lf_valid.
  - clr_fault outside FAULT is ignored.
  - rst mid-operation returns everything to the reset values immediately.
- retries saturates at MAX_RETRY; it never wraps.

Decomposition:
- Package drive_pkg: command constants (FORWARD, BACK, LEFT, RIGHT, P_LEFT, P_RIGHT), beacon codes F/C, state encoding, and a reversal-detect function.
- One sub-module, oc_debounce: ocl_n plus enable in, trip pulse out, parameterised by OC_FILTER.
- PWM counter and state machine stay in drive_sequencer.

Test Plan:
Bench parameters: PERIOD=100, DEADTIME=4, OC_FILTER=8, COOL_TIME=16, MAX_RETRY=2.
- en=1, duty=40, lf_cmd=FORWARD strobed, beacon=0 -> ja=1010 for counts 0..39 and 0 for 40..99 each period; state=001.
- Running FORWARD, strobe BACK -> ja=0 for exactly 4 cycles with state=010, then ja=0101 under PWM. A FORWARD->LEFT change instead gives no DEAD state and ja=1000 the next cycle.
- beacon=0011 with duty=40 -> on-time becomes 20 counts. beacon=1100 -> state=011 and ja=0. beacon=0 -> RUN, and a pending FORWARD applies with no dead-time.
- ocl_n=10 for 7 cycles then 11 -> no trip. ocl_n=10 held 8 cycles -> state=100, retries=1, ja=0 for 16 cycles, then RUN.
- Second trip -> state=101, fault=1, ja=0; en and lf_valid are ignored. clr_fault -> IDLE, retries=0, then RUN.
- Assert rst mid-DEAD and mid-COOL -> all outputs and counters zero within the same cycle; after release, state=IDLE.
